// File: rtl/serial_fetch_engine.sv
// Serial fetch engine: shifts an address out over LANES wires, waits WAIT_CYC cycles,
// shifts a DATA_W word back in and offers it on a valid/ready port. Optional parity beat: SERIAL_FETCH_PARITY_EN.
module serial_fetch_engine #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned LANES    = 1,
    parameter int unsigned WAIT_CYC = 0
) (
    input  logic              sys_clk,
    input  logic              sys_reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              abort,
    output logic [LANES-1:0]  addr_out,
    output logic              addr_out_valid,
    input  logic [LANES-1:0]  data_in,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy
);

    localparam int unsigned AB = ADDR_W / LANES;
    localparam int unsigned DB = DATA_W / LANES;
`ifdef SERIAL_FETCH_PARITY_EN
    localparam int unsigned RB = DB + 1;
`else
    localparam int unsigned RB = DB;
`endif
    localparam int unsigned MAX_AR = (AB > RB) ? AB : RB;
    localparam int unsigned MAX_C  = (MAX_AR > WAIT_CYC) ? MAX_AR : WAIT_CYC;
    localparam int unsigned CNT_W  = $clog2(MAX_C + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_RECV,
        S_HOLD
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nx;
    logic [ADDR_W-1:0]  r_addr_sh;
    logic [ADDR_W-1:0]  w_addr_sh_nx;
    logic [LANES-1:0]   r_addr_out;
    logic [LANES-1:0]   w_addr_out_nx;
    logic               r_addr_vld;
    logic               w_addr_vld_nx;
    logic [DATA_W-1:0]  r_data_sh;
    logic [DATA_W-1:0]  w_data_sh_nx;
    logic [DATA_W-1:0]  r_rsp_data;
    logic [DATA_W-1:0]  w_rsp_data_nx;
    logic               r_rsp_vld;
    logic               r_busy;
    logic               w_accept;
`ifdef SERIAL_FETCH_PARITY_EN
    logic               r_rsp_err;
    logic               w_rsp_err_nx;
`endif

    // Abort and reset both veto the handshake; HOLD can hand over straight to a new request.
    assign req_ready = !sys_reset && !abort &&
                       ((r_state == S_IDLE) || ((r_state == S_HOLD) && rsp_ready));
    assign w_accept  = req_valid && req_ready;

    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt + CNT_W'(1);
        w_addr_sh_nx  = r_addr_sh;
        w_addr_out_nx = '0;
        w_addr_vld_nx = 1'b0;
        w_data_sh_nx  = r_data_sh;
        w_rsp_data_nx = r_rsp_data;
`ifdef SERIAL_FETCH_PARITY_EN
        w_rsp_err_nx  = r_rsp_err;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nx = S_SEND;
            end
            S_SEND: begin
                if (r_cnt == CNT_W'(AB - 1)) w_state_nx = (WAIT_CYC == 0) ? S_RECV : S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == CNT_W'(WAIT_CYC - 1)) w_state_nx = S_RECV;
            end
            S_RECV: begin
`ifdef SERIAL_FETCH_PARITY_EN
                // Final beat carries only the even-parity bit on lane 0.
                if (r_cnt == CNT_W'(DB)) begin
                    w_state_nx    = S_HOLD;
                    w_rsp_data_nx = r_data_sh;
                    w_rsp_err_nx  = (^r_data_sh) != data_in[0];
                end else begin
                    w_data_sh_nx  = (r_data_sh << LANES) | DATA_W'(data_in);
                end
`else
                w_data_sh_nx = (r_data_sh << LANES) | DATA_W'(data_in);
                if (r_cnt == CNT_W'(DB - 1)) begin
                    w_state_nx    = S_HOLD;
                    w_rsp_data_nx = w_data_sh_nx;
                end
`endif
            end
            S_HOLD: begin
                if (rsp_ready) w_state_nx = w_accept ? S_SEND : S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase

        if (abort && (r_state != S_IDLE)) w_state_nx = S_IDLE;
        if (w_state_nx != r_state) w_cnt_nx = '0;

        // Address beats are pre-computed so addr_out is a clean register, MSB beat first.
        if (w_accept) begin
            w_addr_out_nx = req_addr[ADDR_W-1 -: LANES];
            w_addr_sh_nx  = req_addr << LANES;
            w_addr_vld_nx = 1'b1;
        end else if ((r_state == S_SEND) && (w_state_nx == S_SEND)) begin
            w_addr_out_nx = r_addr_sh[ADDR_W-1 -: LANES];
            w_addr_sh_nx  = r_addr_sh << LANES;
            w_addr_vld_nx = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_addr_sh  <= '0;
            r_addr_out <= '0;
            r_addr_vld <= 1'b0;
            r_data_sh  <= '0;
            r_rsp_data <= '0;
            r_rsp_vld  <= 1'b0;
            r_busy     <= 1'b0;
`ifdef SERIAL_FETCH_PARITY_EN
            r_rsp_err  <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_addr_sh  <= w_addr_sh_nx;
            r_addr_out <= w_addr_out_nx;
            r_addr_vld <= w_addr_vld_nx;
            r_data_sh  <= w_data_sh_nx;
            r_rsp_data <= w_rsp_data_nx;
            r_rsp_vld  <= (w_state_nx == S_HOLD);
            r_busy     <= (w_state_nx != S_IDLE);
`ifdef SERIAL_FETCH_PARITY_EN
            r_rsp_err  <= w_rsp_err_nx;
`endif
        end
    end

    assign addr_out       = r_addr_out;
    assign addr_out_valid = r_addr_vld;
    assign rsp_valid      = r_rsp_vld;
    assign rsp_data       = r_rsp_data;
    assign busy           = r_busy;
`ifdef SERIAL_FETCH_PARITY_EN
    assign rsp_err        = r_rsp_err;
`else
    assign rsp_err        = 1'b0;
`endif

endmodule

// File: tb/tb_serial_fetch_engine.sv
// Bench for serial_fetch_engine: two instances (1 lane / no wait, 4 lanes / 3 wait cycles)
// driven from a vector table, a behavioural serial memory and a response scoreboard.
module tb_serial_fetch_engine;

`ifdef SERIAL_FETCH_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rv[2], rr[2], ab[2], aov[2], rsv[2], rdy[2], rerr[2], bsy[2];
    logic [7:0]  ra[2];
    logic [3:0]  ao[2];
    logic [3:0]  di[2];
    logic [15:0] rd[2];
    logic        ao0;
    logic [3:0]  ao1;

    assign ao[0] = {3'b000, ao0};
    assign ao[1] = ao1;

    always #5 clk = ~clk;

    serial_fetch_engine #(.ADDR_W(8), .DATA_W(16), .LANES(1), .WAIT_CYC(0)) u0 (
        .sys_clk(clk), .sys_reset(rst), .req_valid(rv[0]), .req_ready(rr[0]),
        .req_addr(ra[0]), .abort(ab[0]), .addr_out(ao0), .addr_out_valid(aov[0]),
        .data_in(di[0][0:0]), .rsp_valid(rsv[0]), .rsp_ready(rdy[0]),
        .rsp_data(rd[0]), .rsp_err(rerr[0]), .busy(bsy[0])
    );

    serial_fetch_engine #(.ADDR_W(8), .DATA_W(16), .LANES(4), .WAIT_CYC(3)) u1 (
        .sys_clk(clk), .sys_reset(rst), .req_valid(rv[1]), .req_ready(rr[1]),
        .req_addr(ra[1]), .abort(ab[1]), .addr_out(ao1), .addr_out_valid(aov[1]),
        .data_in(di[1]), .rsp_valid(rsv[1]), .rsp_ready(rdy[1]),
        .rsp_data(rd[1]), .rsp_err(rerr[1]), .busy(bsy[1])
    );

    typedef struct {
        logic [15:0] data;
        logic        err;
    } exp_t;

    typedef struct {
        int          d;
        logic [7:0]  a;
        logic [15:0] w;
        logic        pe;
        int          hold;
        bit          b2b;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        sb0[$];
    exp_t        sb1[$];
    vec_t        tbl[$];
    bit          chained = 1'b0;
    logic [15:0] mem_word[2];
    logic        perr[2];
    logic [7:0]  exp_addr[2];
    logic [7:0]  m_addr[2];
    int          m_beats[2];
    int          m_k[2];
    int          m_j;
    bit          m_arm[2];
    exp_t        mon_e;

    function automatic int lanes(input int d);   return (d == 0) ? 1 : 4; endfunction
    function automatic int waitc(input int d);   return (d == 0) ? 0 : 3; endfunction
    function automatic int abeats(input int d);  return 8 / lanes(d); endfunction
    function automatic int dbeats(input int d);  return 16 / lanes(d); endfunction
    function automatic int rbeats(input int d);  return dbeats(d) + PAR; endfunction
    function automatic int exp_lat(input int d); return abeats(d) + waitc(d) + rbeats(d) + 1; endfunction

    function automatic logic [15:0] front_data(input int d);
        if (d == 0) return (sb0.size() > 0) ? sb0[0].data : 16'h0;
        return (sb1.size() > 0) ? sb1[0].data : 16'h0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Serial memory: collects address beats, then drives data beats after the fixed wait.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst || ab[d]) begin
                m_beats[d] = 0;
                m_arm[d]   = 1'b0;
                m_k[d]     = 0;
                di[d]      = 4'($urandom);
            end else if (aov[d]) begin
                m_addr[d] = 8'((m_addr[d] << lanes(d)) | 8'(ao[d]));
                m_beats[d]++;
                if (m_beats[d] == abeats(d)) begin
                    check($sformatf("addr_seen%0d", d), int'(m_addr[d]), int'(exp_addr[d]));
                    m_arm[d]   = 1'b1;
                    m_k[d]     = 0;
                    m_beats[d] = 0;
                end
                di[d] = 4'($urandom);
            end else begin
                check($sformatf("addr_out_zero%0d", d), int'(ao[d]), 0);
                di[d] = 4'($urandom);
                if (m_arm[d]) begin
                    m_k[d]++;
                    m_j = m_k[d] - waitc(d) - 1;
                    if (m_j >= 0 && m_j < dbeats(d))
                        di[d] = 4'(mem_word[d] >> (16 - (m_j + 1) * lanes(d)));
                    else if (m_j == dbeats(d))
                        di[d] = {3'($urandom), (^mem_word[d]) ^ perr[d]};
                    if (m_j == rbeats(d) - 1) m_arm[d] = 1'b0;
                end
            end
        end
    end

    // Scoreboard: every completed handshake pops the oldest expected response.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst && rsv[d] && rdy[d]) begin
                if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
                    check($sformatf("rsp_unexpected%0d", d), 1, 0);
                end else begin
                    if (d == 0) mon_e = sb0.pop_front();
                    else        mon_e = sb1.pop_front();
                    check($sformatf("rsp_data%0d", d), int'(rd[d]), int'(mon_e.data));
                    check($sformatf("rsp_err%0d", d), int'(rerr[d]), int'(mon_e.err));
                end
            end
        end
    end

    task automatic start_req(input int d, input logic [7:0] a, input logic [15:0] w,
                             input logic pe, input bit push);
        bit   ok = 1'b0;
        exp_t e;
        mem_word[d] = w;
        perr[d]     = pe;
        exp_addr[d] = a;
        if (push) begin
            e.data = w;
            e.err  = (PAR != 0) ? pe : 1'b0;
            if (d == 0) sb0.push_back(e);
            else        sb1.push_back(e);
        end
        rv[d] = 1'b1;
        ra[d] = a;
        repeat (50) begin
            @(negedge clk);
            if (rr[d]) begin
                ok = 1'b1;
                break;
            end
        end
        check($sformatf("accept%0d", d), int'(ok), 1);
        if (ok) begin
            @(posedge clk);
            #1;
        end
        rv[d] = 1'b0;
        ra[d] = ~a;
    endtask

    task automatic wait_rsp(input int d, input int hold);
        int lat    = 0;
        bit got    = 1'b0;
        bit stable = 1'b1;
        repeat (200) begin
            @(negedge clk);
            lat++;
            if (lat == 1) check($sformatf("first_beat%0d", d), int'({aov[d], bsy[d]}), 3);
            if (rsv[d]) begin
                got = 1'b1;
                break;
            end
        end
        check($sformatf("latency%0d", d), got ? lat : -1, exp_lat(d));
        repeat (hold) begin
            @(negedge clk);
            if (!rsv[d] || rd[d] !== front_data(d)) stable = 1'b0;
        end
        if (hold > 0) check($sformatf("hold_stable%0d", d), int'(stable), 1);
    endtask

    task automatic run_vec(input vec_t v);
        if (chained) begin
            start_req(v.d, v.a, v.w, v.pe, 1'b1);
            rdy[v.d] = 1'b0;
            chained  = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            start_req(v.d, v.a, v.w, v.pe, 1'b1);
        end
        wait_rsp(v.d, v.hold);
        @(posedge clk);
        #1;
        rdy[v.d] = 1'b1;
        if (v.b2b) begin
            chained = 1'b1;
        end else begin
            @(posedge clk);
            #1;
            rdy[v.d] = 1'b0;
            @(negedge clk);
            check($sformatf("idle_after%0d", v.d), int'({rsv[v.d], bsy[v.d], aov[v.d]}), 0);
        end
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            rv[d] = 1'b0; ab[d] = 1'b0; rdy[d] = 1'b0; ra[d] = 8'h00;
            mem_word[d] = 16'h0; perr[d] = 1'b0; exp_addr[d] = 8'h0;
        end
        tbl.push_back('{0, 8'hA5, 16'h1234, 1'b0, 5, 1'b1});
        tbl.push_back('{0, 8'h01, 16'hCAFE, 1'b0, 0, 1'b0});
        tbl.push_back('{1, 8'h3C, 16'hBEEF, 1'b0, 2, 1'b0});
        tbl.push_back('{1, 8'hC3, 16'h0F5A, 1'b0, 0, 1'b1});
        tbl.push_back('{1, 8'hFF, 16'hFFFF, 1'b0, 1, 1'b0});
        tbl.push_back('{0, 8'h00, 16'h0000, 1'b0, 0, 1'b0});
`ifdef SERIAL_FETCH_PARITY_EN
        tbl.push_back('{0, 8'h10, 16'h0001, 1'b1, 0, 1'b0});
        tbl.push_back('{0, 8'h11, 16'h0001, 1'b0, 0, 1'b0});
        tbl.push_back('{1, 8'h12, 16'h8421, 1'b1, 0, 1'b0});
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_outs%0d", d),
                  int'({aov[d], rsv[d], bsy[d], rerr[d], rr[d]}), 0);
            check($sformatf("reset_data%0d", d), int'(rd[d]), 0);
            check($sformatf("reset_addr_out%0d", d), int'(ao[d]), 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset0", int'(rr[0]), 1);
        check("ready_after_reset1", int'(rr[1]), 1);

        foreach (tbl[i]) run_vec(tbl[i]);

        // Abort while idle: request refused, nothing starts.
        @(posedge clk);
        #1;
        ab[0] = 1'b1; rv[0] = 1'b1; ra[0] = 8'h55;
        @(negedge clk);
        check("abort_idle_ready", int'(rr[0]), 0);
        @(posedge clk);
        #1;
        ab[0] = 1'b0; rv[0] = 1'b0;
        @(negedge clk);
        check("abort_idle_busy", int'({bsy[0], aov[0]}), 0);

        // Abort in the fourth SEND cycle.
        @(posedge clk);
        #1;
        start_req(0, 8'h42, 16'h9999, 1'b0, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        ab[0] = 1'b1;
        @(negedge clk);
        check("abort_cycle_sending", int'({aov[0], bsy[0]}), 3);
        @(posedge clk);
        #1;
        ab[0] = 1'b0;
        @(negedge clk);
        check("abort_next_cycle", int'({bsy[0], aov[0], rsv[0]}), 0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (rsv[0]) seen = 1'b1;
        end
        check("abort_no_rsp", int'(seen), 0);
        run_vec('{0, 8'h7F, 16'h5A3C, 1'b0, 0, 1'b0});

        // Reset pulse in the middle of RECV on the 4-lane instance.
        @(posedge clk);
        #1;
        start_req(1, 8'h99, 16'h1357, 1'b0, 1'b0);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", int'(bsy[1]), 1);
        check("rst_ready_low", int'({rr[0], rr[1]}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_outs", int'({aov[1], rsv[1], bsy[1], rerr[1]}), 0);
        check("rst_mid_data", int'(rd[1]), 0);
        check("rst_mid_addr_out", int'(ao[1]), 0);
        check("rst_mid_ready", int'(rr[1]), 1);
        run_vec('{1, 8'h5E, 16'hA0C1, 1'b0, 0, 1'b0});

        check("sb_empty", sb0.size() + sb1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
